// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
//
// Pipeline hazard control unit. Produces the stall and flush strobes for the
// PC, IF/ID, ID/EX and EX/MEM pipeline registers from three hazard sources:
//   * load-use data hazards between the ID and EX stages,
//   * taken branches resolved in EX, including a flush that must outlive a
//     slow instruction fetch,
//   * multi-cycle multiply/divide operations, sequenced by a counter FSM.
//
// Handshake note: ex_md_start is a level held high by EX for as long as the
// mult/div instruction stays in EX. It is accepted only in IDLE. md_done is a
// one-cycle pulse in which no stall is raised, so the instruction leaves EX on
// the following edge. There is no other valid/ready style handshake here.
//
// Parameters:
//   MULT_CYCLES  stall cycles for a multiply (1..63)
//   DIV_CYCLES   stall cycles for a divide   (1..63)
//
// Ports:
//   clk              in   pipeline clock, rising-edge active
//   rst              in   asynchronous active-high reset; forces outputs to 0
//   id_Rs, id_Rt     in   source registers of the instruction in ID
//   id_use_rs/rt     in   the ID instruction actually reads Rs / Rt
//   ex_MemRead       in   instruction in EX is a load
//   ex_wreg          in   destination register of the instruction in EX
//   ex_branch_taken  in   branch/jump in EX is taken this cycle
//   ex_md_start      in   EX instruction is mult/div (held while in EX)
//   ex_md_is_div     in   1 = divide, 0 = multiply
//   inst_ready       in   instruction memory delivers a word this cycle
//   stall_pc         out  hold the PC
//   stall_if_id      out  hold IF/ID
//   flush_if_id      out  bubble into IF/ID
//   stall_id_ex      out  hold ID/EX
//   flush_id_ex      out  bubble into ID/EX
//   flush_ex_mem     out  bubble into EX/MEM
//   md_busy          out  mult/div sequencer is in BUSY (FSM state view)
//   md_done          out  one-cycle pulse: mult/div result valid
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
   parameter int MULT_CYCLES = 3,
   parameter int DIV_CYCLES  = 33
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [4:0] id_Rs,
   input  logic [4:0] id_Rt,
   input  logic       id_use_rs,
   input  logic       id_use_rt,
   input  logic       ex_MemRead,
   input  logic [4:0] ex_wreg,
   input  logic       ex_branch_taken,
   input  logic       ex_md_start,
   input  logic       ex_md_is_div,
   input  logic       inst_ready,
   output logic       stall_pc,
   output logic       stall_if_id,
   output logic       flush_if_id,
   output logic       stall_id_ex,
   output logic       flush_id_ex,
   output logic       flush_ex_mem,
   output logic       md_busy,
   output logic       md_done
);

   typedef enum logic {
      MD_IDLE = 1'b0,
      MD_BUSY = 1'b1
   } md_state_t;

   // Counter preload values. The start cycle is itself a stall cycle, so
   // BUSY only has to cover the remaining N-1 stall cycles.
   localparam logic [5:0] MULT_LOAD = 6'(MULT_CYCLES - 1);
   localparam logic [5:0] DIV_LOAD  = 6'(DIV_CYCLES - 1);

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   md_state_t  state;
   logic [5:0] cnt;
   logic       pend_flush;

   // ---------------------------------------------------------------------------
   // Internal hazard terms (before reset gating)
   // ---------------------------------------------------------------------------
   logic       md_stall;
   logic       md_fin;
   logic       rs_hit;
   logic       rt_hit;
   logic       load_use;
   logic       lu_eff;
   logic       br_eff;
   logic       stall_if_raw;
   logic       flush_if_raw;
   logic       pend_next;

   // Mult/div stall: the accepting cycle plus every BUSY cycle with work left.
   // The BUSY cycle with cnt==0 is the done cycle and is deliberately stall-free.
   always_comb begin
      md_stall = 1'b0;
      md_fin   = 1'b0;
      case (state)
         MD_IDLE: md_stall = ex_md_start;
         MD_BUSY: begin
            md_stall = (cnt != 6'd0);
            md_fin   = (cnt == 6'd0);
         end
         default: begin
            md_stall = 1'b0;
            md_fin   = 1'b0;
         end
      endcase
   end

   // Load-use detection. Register 0 is hard-wired zero, so a load targeting it
   // never creates a real dependency.
   always_comb begin
      rs_hit   = id_use_rs && (id_Rs == ex_wreg);
      rt_hit   = id_use_rt && (id_Rt == ex_wreg);
      load_use = ex_MemRead && (ex_wreg != 5'd0) && (rs_hit || rt_hit);
   end

   // A mult/div stall freezes EX, so a load-use or branch seen in the same
   // cycle is not yet real: both are masked until EX moves again.
   always_comb begin
      lu_eff       = load_use && !md_stall;
      br_eff       = ex_branch_taken && !md_stall;
      stall_if_raw = md_stall || lu_eff;
      // Bubble IF/ID when fetch has nothing valid, when a taken branch must
      // squash the wrong-path fetch, or when such a squash is still owed.
      // A hold on IF/ID always wins over the bubble.
      flush_if_raw = (!inst_ready || br_eff || pend_flush) && !stall_if_raw;
   end

   // pend_flush remembers a branch squash that arrived while fetch was still
   // waiting. It is released on the first cycle IF/ID can actually accept a
   // valid word; that cycle still flushes, squashing the late wrong-path word.
   always_comb begin
      pend_next = pend_flush;
      if (br_eff && !inst_ready) begin
         pend_next = 1'b1;
      end else if (inst_ready && !stall_if_raw) begin
         pend_next = 1'b0;
      end
   end

   // ---------------------------------------------------------------------------
   // Mult/div sequencer
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= MD_IDLE;
         cnt   <= 6'd0;
      end else begin
         case (state)
            MD_IDLE: begin
               if (ex_md_start) begin
                  // A one-cycle operation loads zero and goes straight to the
                  // done cycle.
                  cnt   <= ex_md_is_div ? DIV_LOAD : MULT_LOAD;
                  state <= MD_BUSY;
               end
            end
            MD_BUSY: begin
               if (cnt != 6'd0) begin
                  cnt <= cnt - 6'd1;
               end else begin
                  state <= MD_IDLE;
               end
            end
            default: begin
               state <= MD_IDLE;
               cnt   <= 6'd0;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Pending branch flush
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend_flush <= 1'b0;
      end else begin
         pend_flush <= pend_next;
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs. Everything is held low while reset is asserted, including terms
   // that would otherwise follow the inputs combinationally.
   // ---------------------------------------------------------------------------
   assign stall_pc     = !rst && (stall_if_raw || !inst_ready);
   assign stall_if_id  = !rst && stall_if_raw;
   assign flush_if_id  = !rst && flush_if_raw;
   assign stall_id_ex  = !rst && md_stall;
   assign flush_id_ex  = !rst && lu_eff;
   assign flush_ex_mem = !rst && md_stall;
   assign md_busy      = !rst && (state == MD_BUSY);
   assign md_done      = !rst && md_fin;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

  localparam int MULT_N = 3;
  localparam int DIV_N  = 33;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_Rs;
  logic [4:0] id_Rt;
  logic       id_use_rs;
  logic       id_use_rt;
  logic       ex_MemRead;
  logic [4:0] ex_wreg;
  logic       ex_branch_taken;
  logic       ex_md_start;
  logic       ex_md_is_div;
  logic       inst_ready;
  logic       stall_pc;
  logic       stall_if_id;
  logic       flush_if_id;
  logic       stall_id_ex;
  logic       flush_id_ex;
  logic       flush_ex_mem;
  logic       md_busy;
  logic       md_done;

  logic [7:0] outs;
  logic [7:0] exp_outs;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: a mult/div op is a time window [m_s, m_s+m_n] on a
  // cycle counter; m_owed is "a branch squash not yet delivered".
  int m_cyc = 0;
  bit m_op = 1'b0;
  int m_s = 0;
  int m_n = 0;
  bit m_owed = 1'b0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  pipe_hazard_ctrl #(
    .MULT_CYCLES(MULT_N),
    .DIV_CYCLES (DIV_N)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .id_Rs          (id_Rs),
    .id_Rt          (id_Rt),
    .id_use_rs      (id_use_rs),
    .id_use_rt      (id_use_rt),
    .ex_MemRead     (ex_MemRead),
    .ex_wreg        (ex_wreg),
    .ex_branch_taken(ex_branch_taken),
    .ex_md_start    (ex_md_start),
    .ex_md_is_div   (ex_md_is_div),
    .inst_ready     (inst_ready),
    .stall_pc       (stall_pc),
    .stall_if_id    (stall_if_id),
    .flush_if_id    (flush_if_id),
    .stall_id_ex    (stall_id_ex),
    .flush_id_ex    (flush_id_ex),
    .flush_ex_mem   (flush_ex_mem),
    .md_busy        (md_busy),
    .md_done        (md_done)
  );

  // {stall_pc, stall_if_id, flush_if_id, stall_id_ex, flush_id_ex, flush_ex_mem, md_busy, md_done}
  assign outs = {stall_pc, stall_if_id, flush_if_id, stall_id_ex,
                 flush_id_ex, flush_ex_mem, md_busy, md_done};

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    rst             = 1'b0;
    id_Rs           = 5'd0;
    id_Rt           = 5'd0;
    id_use_rs       = 1'b0;
    id_use_rt       = 1'b0;
    ex_MemRead      = 1'b0;
    ex_wreg         = 5'd0;
    ex_branch_taken = 1'b0;
    ex_md_start     = 1'b0;
    ex_md_is_div    = 1'b0;
    inst_ready      = 1'b1;
  endtask

  // Lets the combinational outputs settle, computes the expected outputs for
  // this cycle from the hazard rules, then advances the model past the
  // upcoming rising edge. Called exactly once per clock cycle.
  task automatic predict();
    bit stall, done, busy, lu, br, sif;
    #2;
    stall = 1'b0;
    done  = 1'b0;
    busy  = 1'b0;
    if (rst) begin
      exp_outs = 8'h00;
      m_op     = 1'b0;
      m_owed   = 1'b0;
    end else begin
      if (m_op) begin
        stall = (m_cyc < m_s + m_n);
        done  = (m_cyc == m_s + m_n);
        busy  = (m_cyc > m_s);
      end else begin
        stall = ex_md_start;
      end
      lu  = !stall && ex_MemRead && (ex_wreg != 5'd0) &&
            ((id_use_rs && id_Rs == ex_wreg) || (id_use_rt && id_Rt == ex_wreg));
      br  = !stall && ex_branch_taken;
      sif = stall || lu;
      exp_outs = {sif || !inst_ready, sif, !sif && (!inst_ready || br || m_owed),
                  stall, lu, stall, busy, done};
      if (!m_op && ex_md_start) begin
        m_op = 1'b1;
        m_s  = m_cyc;
        m_n  = ex_md_is_div ? DIV_N : MULT_N;
      end else if (m_op && done) begin
        m_op = 1'b0;
      end
      if (br && !inst_ready) m_owed = 1'b1;
      else if (inst_ready && !sif) m_owed = 1'b0;
    end
    m_cyc++;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    for (int c = 0; c < 4; c++) begin
      next_cycle();
      rst             = 1'b1;
      id_Rs           = 5'($urandom_range(0, 31));
      id_Rt           = id_Rs;
      id_use_rs       = 1'b1;
      id_use_rt       = 1'b1;
      ex_MemRead      = 1'b1;
      ex_wreg         = 5'd7;
      ex_branch_taken = 1'b1;
      ex_md_start     = 1'b1;
      ex_md_is_div    = 1'($urandom_range(0, 1));
      inst_ready      = 1'b0;
      predict();
      n_checks++;
      if (outs !== 8'h00) begin
        n_fail++;
        $display("FAIL reset_outputs got=%b exp=%b", outs, 8'h00);
      end
    end
    next_cycle();
    idle_inputs();
    predict();
    n_checks++;
    if (outs !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_release got=%b exp=%b", outs, 8'h00);
    end
  endtask

  task automatic test_load_use();
    next_cycle();
    idle_inputs();
    ex_MemRead = 1'b1;
    ex_wreg    = 5'd5;
    id_Rs      = 5'd5;
    id_use_rs  = 1'b1;
    predict();
    n_checks++;
    if (outs !== 8'b1100_1000) begin
      n_fail++;
      $display("FAIL load_use_rs got=%b exp=%b", outs, 8'b1100_1000);
    end
    // Dependency through Rt only.
    next_cycle();
    idle_inputs();
    ex_MemRead = 1'b1;
    ex_wreg    = 5'd9;
    id_Rt      = 5'd9;
    id_use_rt  = 1'b1;
    id_Rs      = 5'd9;
    predict();
    n_checks++;
    if (outs !== 8'b1100_1000) begin
      n_fail++;
      $display("FAIL load_use_rt got=%b exp=%b", outs, 8'b1100_1000);
    end
    // Load into r0 is never a hazard.
    next_cycle();
    idle_inputs();
    ex_MemRead = 1'b1;
    ex_wreg    = 5'd0;
    id_Rs      = 5'd0;
    id_use_rs  = 1'b1;
    predict();
    n_checks++;
    if (outs !== 8'h00) begin
      n_fail++;
      $display("FAIL load_use_r0 got=%b exp=%b", outs, 8'h00);
    end
    // Matching register but not read by ID.
    next_cycle();
    idle_inputs();
    ex_MemRead = 1'b1;
    ex_wreg    = 5'd5;
    id_Rs      = 5'd5;
    predict();
    n_checks++;
    if (outs !== 8'h00) begin
      n_fail++;
      $display("FAIL load_use_unused got=%b exp=%b", outs, 8'h00);
    end
  endtask

  task automatic test_mult_div(input bit is_div, input int n);
    int stalls  = 0;
    int busies  = 0;
    int done_at = -1;
    for (int c = 1; c <= n + 1; c++) begin
      next_cycle();
      idle_inputs();
      ex_md_start  = 1'b1;
      ex_md_is_div = is_div;
      predict();
      n_checks++;
      if (outs !== exp_outs) begin
        n_fail++;
        $display("FAIL md_seq div=%0d cycle=%0d got=%b exp=%b", is_div, c, outs, exp_outs);
      end
      if (stall_id_ex && flush_ex_mem && stall_pc) stalls++;
      if (md_busy && c >= 2) busies++;
      if (md_done && done_at < 0) done_at = c;
    end
    next_cycle();
    idle_inputs();
    predict();
    n_checks++;
    if (outs !== 8'h00) begin
      n_fail++;
      $display("FAIL md_after div=%0d got=%b exp=%b", is_div, outs, 8'h00);
    end
    n_checks++;
    if (stalls != n) begin
      n_fail++;
      $display("FAIL md_stall_count div=%0d got=%0d exp=%0d", is_div, stalls, n);
    end
    n_checks++;
    if (done_at != n + 1) begin
      n_fail++;
      $display("FAIL md_done_cycle div=%0d got=%0d exp=%0d", is_div, done_at, n + 1);
    end
    n_checks++;
    if (busies != n) begin
      n_fail++;
      $display("FAIL md_busy_count div=%0d got=%0d exp=%0d", is_div, busies, n);
    end
  endtask

  task automatic test_back_to_back();
    int dones = 0;
    // Two multiplies, start held continuously: second is accepted right after
    // the first md_done.
    for (int c = 1; c <= 2 * (MULT_N + 1); c++) begin
      next_cycle();
      idle_inputs();
      ex_md_start = 1'b1;
      predict();
      n_checks++;
      if (outs !== exp_outs) begin
        n_fail++;
        $display("FAIL b2b cycle=%0d got=%b exp=%b", c, outs, exp_outs);
      end
      if (md_done) dones++;
    end
    next_cycle();
    idle_inputs();
    predict();
    n_checks++;
    if (dones != 2) begin
      n_fail++;
      $display("FAIL b2b_done_count got=%0d exp=%0d", dones, 2);
    end
  endtask

  task automatic test_branch_ready();
    next_cycle();
    idle_inputs();
    ex_branch_taken = 1'b1;
    predict();
    n_checks++;
    if (outs !== 8'b0010_0000) begin
      n_fail++;
      $display("FAIL branch_ready got=%b exp=%b", outs, 8'b0010_0000);
    end
    next_cycle();
    idle_inputs();
    predict();
    n_checks++;
    if (outs !== 8'h00) begin
      n_fail++;
      $display("FAIL branch_ready_after got=%b exp=%b", outs, 8'h00);
    end
  endtask

  task automatic test_branch_slow();
    for (int c = 1; c <= 6; c++) begin
      next_cycle();
      idle_inputs();
      ex_branch_taken = (c == 1);
      inst_ready      = (c >= 5);
      predict();
      n_checks++;
      if (flush_if_id !== (c <= 5) || outs !== exp_outs) begin
        n_fail++;
        $display("FAIL branch_slow cycle=%0d got=%b exp=%b", c, outs, exp_outs);
      end
    end
  endtask

  task automatic test_lu_fetch_wait();
    next_cycle();
    idle_inputs();
    inst_ready = 1'b0;
    ex_MemRead = 1'b1;
    ex_wreg    = 5'd12;
    id_Rt      = 5'd12;
    id_use_rt  = 1'b1;
    predict();
    n_checks++;
    if (outs !== 8'b1100_1000) begin
      n_fail++;
      $display("FAIL lu_fetch_wait got=%b exp=%b", outs, 8'b1100_1000);
    end
  endtask

  task automatic test_reset_mid_op();
    int dones = 0;
    for (int c = 1; c <= 11; c++) begin
      next_cycle();
      idle_inputs();
      ex_md_start  = 1'b1;
      ex_md_is_div = 1'b1;
      rst          = (c == 11);
      predict();
      if (c == 11) begin
        n_checks++;
        if (outs !== 8'h00) begin
          n_fail++;
          $display("FAIL reset_mid_op got=%b exp=%b", outs, 8'h00);
        end
      end
    end
    for (int c = 0; c < 2; c++) begin
      next_cycle();
      rst = 1'b1;
      predict();
    end
    for (int c = 0; c < 40; c++) begin
      next_cycle();
      idle_inputs();
      predict();
      n_checks++;
      if (outs !== exp_outs) begin
        n_fail++;
        $display("FAIL after_abort cycle=%0d got=%b exp=%b", c, outs, exp_outs);
      end
      if (md_done) dones++;
    end
    n_checks++;
    if (dones != 0) begin
      n_fail++;
      $display("FAIL abort_done_pulses got=%0d exp=%0d", dones, 0);
    end
  endtask

  task automatic test_random();
    int errs = 0;
    for (int c = 0; c < 2000; c++) begin
      next_cycle();
      rst             = ($urandom_range(0, 199) == 0);
      id_Rs           = 5'($urandom_range(0, 3));
      id_Rt           = 5'($urandom_range(0, 3));
      id_use_rs       = 1'($urandom_range(0, 1));
      id_use_rt       = 1'($urandom_range(0, 1));
      ex_MemRead      = 1'($urandom_range(0, 1));
      ex_wreg         = 5'($urandom_range(0, 3));
      ex_branch_taken = ($urandom_range(0, 3) == 0);
      ex_md_start     = ($urandom_range(0, 9) == 0);
      ex_md_is_div    = ($urandom_range(0, 3) == 0);
      inst_ready      = ($urandom_range(0, 2) != 0);
      predict();
      n_checks++;
      if (outs !== exp_outs) begin
        n_fail++;
        errs++;
        if (errs <= 10)
          $display("FAIL random cycle=%0d got=%b exp=%b", c, outs, exp_outs);
      end
    end
  endtask

  // ---------------- main sequence and report ----------------
  initial begin
    idle_inputs();
    rst = 1'b1;
    test_reset();
    test_load_use();
    test_mult_div(1'b1, DIV_N);
    test_mult_div(1'b0, MULT_N);
    test_back_to_back();
    test_branch_ready();
    test_branch_slow();
    test_lu_fetch_wait();
    test_reset_mid_op();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
